exhaustive_pattern_sequencer: RTL and testbench

- Hardware controller that sequences a small combinational or sequential block under test (BUT) through all 2^N_IN input vectors, in ascending order.
- For each vector it waits a programmable settle time, then captures the single-bit BUT response into a response vector.
- At the end it compares the response vector against a golden vector and flags a mismatch, giving on-chip trojan or functional screening.
- Sits between the control host (start/done handshake) and the BUT's input/output pins.

---
 rtl/exhaustive_pattern_sequencer_pkg.sv | 24 ++
 rtl/exhaustive_pattern_sequencer_settle_timer.sv | 40 ++++
 rtl/exhaustive_pattern_sequencer.sv | 134 +++++++++++++
 tb/tb_exhaustive_pattern_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/exhaustive_pattern_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pattern_seq_pkg
// Shared types and constants for the exhaustive pattern sequencer.
//   state_t  : sequencer FSM states
//   SETTLE_W : width of the settle-time down-counter
//   n_pat()  : number of patterns for a given BUT input width (2^n_in)
// -----------------------------------------------------------------------------
package pattern_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    CMP     = 3'd4
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int n_pat(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/exhaustive_pattern_sequencer_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Down-counter that measures the settle interval between driving a pattern and
// sampling the BUT response.
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset, clears the count
//   load     : load load_val into the counter (has priority over en)
//   load_val : number of settle cycles to wait
//   en       : decrement while waiting
//   expire   : high during the last waiting cycle (count has reached 1)
// -----------------------------------------------------------------------------
module settle_timer
  import pattern_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  output logic                expire
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  // A count of N loaded in APPLY gives exactly N cycles in WAIT: the cycle
  // that observes count==1 is the last one. Count 0 also reports expired so a
  // stray enable can never stall the sequencer.
  assign expire = (count <= SETTLE_W'(1));

endmodule

// File: rtl/exhaustive_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// exhaustive_pattern_sequencer
// Drives a block under test (BUT) through all 2^N_IN input patterns in
// ascending order, waits SETTLE cycles per pattern, captures the one-bit BUT
// response into resp_vec and finally compares resp_vec with golden.
//
// Host handshake: a sweep is requested by holding start high across a rising
// edge while busy is low; start is ignored while busy. Completion is signalled
// by a single-cycle done pulse; resp_vec and mismatch are valid from that
// cycle and hold until the next accepted start. abort while busy returns to
// IDLE immediately with cleared results and no done pulse; in IDLE abort has
// no effect.
//
// Ports:
//   CK        : clock, rising edge
//   reset     : synchronous active-low reset
//   start     : begin a sweep (sampled only in IDLE)
//   abort     : cancel an active sweep
//   golden    : expected responses, bit i for pattern i (sampled in CMP)
//   but_out   : BUT response bit (sampled only in CAPTURE)
//   pat       : pattern driven to the BUT
//   busy      : high in every state except IDLE
//   done      : one-cycle completion pulse
//   resp_vec  : captured responses, bit i for pattern i
//   mismatch  : resp_vec != golden, valid from done until the next start
//   fsm_state : current FSM state, for observation
// -----------------------------------------------------------------------------
module exhaustive_pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter  int N_IN   = 4,
  parameter  int SETTLE = 1,
  localparam int N_PAT  = n_pat(N_IN)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [N_PAT-1:0] golden,
  input  logic             but_out,
  output logic [N_IN-1:0]  pat,
  output logic             busy,
  output logic             done,
  output logic [N_PAT-1:0] resp_vec,
  output logic             mismatch,
  output state_t           fsm_state
);

  // One extra bit so the index never wraps when checking for the last pattern.
  localparam int IDX_W = N_IN + 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_PAT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

  state_t           state;
  logic [IDX_W-1:0] index;
  logic             settle_expire;

  settle_timer u_settle_timer (
    .clk      (CK),
    .reset    (reset),
    .load     (state == APPLY),
    .load_val (SETTLE_V),
    .en       (state == WAIT),
    .expire   (settle_expire)
  );

  always_ff @(posedge CK) begin
    if (!reset) begin
      state    <= IDLE;
      index    <= '0;
      pat      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      resp_vec <= '0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort overrides every transition out of a busy state, including the
      // final CAPTURE and CMP, so an aborted sweep never reports done.
      if ((state != IDLE) && abort) begin
        state    <= IDLE;
        index    <= '0;
        pat      <= '0;
        busy     <= 1'b0;
        resp_vec <= '0;
        mismatch <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= APPLY;
              index    <= '0;
              busy     <= 1'b1;
              resp_vec <= '0;
              mismatch <= 1'b0;
            end
          end
          APPLY: begin
            pat   <= index[N_IN-1:0];
            state <= (SETTLE > 0) ? WAIT : CAPTURE;
          end
          WAIT: begin
            if (settle_expire) begin
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            resp_vec[index[N_IN-1:0]] <= but_out;
            if (index == LAST_IDX) begin
              state <= CMP;
            end else begin
              index <= index + IDX_W'(1);
              state <= APPLY;
            end
          end
          CMP: begin
            // resp_vec already holds the last captured bit at this point.
            mismatch <= (resp_vec != golden);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_exhaustive_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exhaustive_pattern_sequencer
// Directed bench for the exhaustive pattern sequencer. Two instances share
// clock and reset: u_dut1 (SETTLE=1) screens an AND4 BUT with an optional
// trojan, u_dut0 (SETTLE=0) screens an XOR4 BUT. Inputs are driven and outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_exhaustive_pattern_sequencer;
  import pattern_seq_pkg::*;

  logic        clk;
  logic        reset;

  logic        start1, abort1, but_out1, trojan;
  logic [15:0] golden1;
  logic [3:0]  pat1;
  logic        busy1, done1, mismatch1;
  logic [15:0] resp_vec1;
  state_t      fsm1;

  logic        start0, abort0, but_out0;
  logic [15:0] golden0;
  logic [3:0]  pat0;
  logic        busy0, done0, mismatch0;
  logic [15:0] resp_vec0;
  state_t      fsm0;

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BUT models: AND4 with a trojan that flips the output at 4'b1010; XOR4.
  assign but_out1 = (&pat1) ^ (trojan && (pat1 == 4'b1010));
  assign but_out0 = ^pat0;

  exhaustive_pattern_sequencer #(.N_IN(4), .SETTLE(1)) u_dut1 (
    .CK(clk), .reset(reset), .start(start1), .abort(abort1),
    .golden(golden1), .but_out(but_out1), .pat(pat1), .busy(busy1),
    .done(done1), .resp_vec(resp_vec1), .mismatch(mismatch1),
    .fsm_state(fsm1)
  );

  exhaustive_pattern_sequencer #(.N_IN(4), .SETTLE(0)) u_dut0 (
    .CK(clk), .reset(reset), .start(start0), .abort(abort0),
    .golden(golden0), .but_out(but_out0), .pat(pat0), .busy(busy0),
    .done(done0), .resp_vec(resp_vec0), .mismatch(mismatch0),
    .fsm_state(fsm0)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Start pulse across one rising edge (edge k); returns at the falling edge
  // right after edge k.
  task automatic start_pulse1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic start_pulse0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Watches u_dut1 for ncyc cycles after edge k. Cycle j is the falling edge
  // after edge k+j. first_done is the first j with done high, ndone the number
  // of cycles done was high, order_err counts pat steps other than +1, nchg
  // counts pat changes. If repulse_at > 0, start is held high across edge
  // k+repulse_at.
  task automatic watch1(input int ncyc, input int repulse_at,
                        output int first_done, output int ndone,
                        output int order_err, output int nchg);
    logic [3:0] prev;
    first_done = -1;
    ndone      = 0;
    order_err  = 0;
    nchg       = 0;
    prev       = pat1;
    for (int j = 1; j <= ncyc; j++) begin
      start1 = (j == repulse_at);
      @(negedge clk);
      if (done1) begin
        ndone++;
        if (first_done < 0) first_done = j;
      end
      if (pat1 != prev) begin
        nchg++;
        if (pat1 != prev + 4'd1) order_err++;
      end
      prev = pat1;
    end
    start1 = 1'b0;
  endtask

  task automatic watch0(input int ncyc, output int first_done,
                        output int ndone, output int wait_seen);
    first_done = -1;
    ndone      = 0;
    wait_seen  = 0;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      if (done0) begin
        ndone++;
        if (first_done < 0) first_done = j;
      end
      if (fsm0 == WAIT) wait_seen++;
    end
  endtask

  initial begin
    int fd, nd, oe, nc, ws;
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b0;
    start1  = 1'b0; abort1 = 1'b0; golden1 = 16'h0000; trojan = 1'b0;
    start0  = 1'b0; abort0 = 1'b0; golden0 = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pat",      32'(pat1),      32'h0);
    check("rst_busy",     32'(busy1),     32'h0);
    check("rst_done",     32'(done1),     32'h0);
    check("rst_resp_vec", 32'(resp_vec1), 32'h0);
    check("rst_mismatch", 32'(mismatch1), 32'h0);
    check("rst_state",    32'(fsm1),      32'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    // AND4, SETTLE=1: done visible after edge k+49, i.e. high at edge k+50
    golden1 = 16'h8000;
    start_pulse1();
    check("and_busy", 32'(busy1), 32'h1);
    watch1(60, 0, fd, nd, oe, nc);
    check("and_done_time",  32'(fd),        32'd49);
    check("and_done_count", 32'(nd),        32'd1);
    check("and_pat_order",  32'(oe),        32'd0);
    check("and_pat_steps",  32'(nc),        32'd15);
    check("and_resp_vec",   32'(resp_vec1), 32'h8000);
    check("and_mismatch",   32'(mismatch1), 32'h0);
    check("and_pat_hold",   32'(pat1),      32'hf);
    check("and_busy_end",   32'(busy1),     32'h0);

    // AND4 with trojan at 4'b1010
    trojan = 1'b1;
    start_pulse1();
    watch1(60, 0, fd, nd, oe, nc);
    check("troj_done_time", 32'(fd),        32'd49);
    check("troj_resp_vec",  32'(resp_vec1), 32'h8400);
    check("troj_mismatch",  32'(mismatch1), 32'h1);

    // Abort while pat==7; the new start first clears the previous results
    trojan = 1'b0;
    start_pulse1();
    check("abt_clr_mismatch", 32'(mismatch1), 32'h0);
    check("abt_clr_resp",     32'(resp_vec1), 32'h0);
    for (int i = 0; i < 40 && pat1 != 4'd7; i++) @(negedge clk);
    check("abt_reach_pat7", 32'(pat1), 32'h7);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("abt_busy",     32'(busy1),     32'h0);
    check("abt_resp_vec", 32'(resp_vec1), 32'h0);
    check("abt_pat",      32'(pat1),      32'h0);
    check("abt_state",    32'(fsm1),      32'(IDLE));
    watch1(60, 0, fd, nd, oe, nc);
    check("abt_no_done", 32'(nd), 32'd0);

    // Clean sweep after abort
    start_pulse1();
    watch1(60, 0, fd, nd, oe, nc);
    check("post_abt_done_time", 32'(fd),        32'd49);
    check("post_abt_done_cnt",  32'(nd),        32'd1);
    check("post_abt_resp_vec",  32'(resp_vec1), 32'h8000);
    check("post_abt_mismatch",  32'(mismatch1), 32'h0);

    // XOR4, SETTLE=0: done visible after edge k+33, never in WAIT
    golden0 = 16'h6996;
    start_pulse0();
    watch0(50, fd, nd, ws);
    check("xor_done_time",  32'(fd),        32'd33);
    check("xor_done_count", 32'(nd),        32'd1);
    check("xor_no_wait",    32'(ws),        32'd0);
    check("xor_resp_vec",   32'(resp_vec0), 32'h6996);
    check("xor_mismatch",   32'(mismatch0), 32'h0);

    // start re-pulsed mid-sweep is ignored
    start_pulse1();
    watch1(60, 10, fd, nd, oe, nc);
    check("repulse_done_time", 32'(fd),        32'd49);
    check("repulse_done_cnt",  32'(nd),        32'd1);
    check("repulse_resp_vec",  32'(resp_vec1), 32'h8000);

    // start and abort together in IDLE: start wins
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    check("start_abort_busy",  32'(busy1), 32'h1);
    check("start_abort_state", 32'(fsm1),  32'(APPLY));

    // Reset mid-sweep
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_pat",      32'(pat1),      32'h0);
    check("mid_rst_busy",     32'(busy1),     32'h0);
    check("mid_rst_done",     32'(done1),     32'h0);
    check("mid_rst_resp_vec", 32'(resp_vec1), 32'h0);
    check("mid_rst_mismatch", 32'(mismatch1), 32'h0);
    check("mid_rst_state",    32'(fsm1),      32'(IDLE));
    reset = 1'b1;
    watch1(60, 0, fd, nd, oe, nc);
    check("mid_rst_no_done", 32'(nd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
